// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// instruction classes, opcode/funct/rt constants, ALU codes and datapath
// mux selects.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_MDU    = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_ILLEGAL = 4'd0,
        C_ALU_R   = 4'd1,
        C_ALU_I   = 4'd2,
        C_LOAD    = 4'd3,
        C_STORE   = 4'd4,
        C_BRANCH  = 4'd5,
        C_J       = 4'd6,
        C_JAL     = 4'd7,
        C_JR      = 4'd8,
        C_JALR    = 4'd9,
        C_MDU     = 4'd10,
        C_MTHI    = 4'd11,
        C_MTLO    = 4'd12,
        C_MFHI    = 4'd13,
        C_MFLO    = 4'd14
    } iclass_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_LBU    = 6'b100100;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SW     = 6'b101011;

    // R-type funct (IR[5:0])
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_JALR  = 6'b001001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    // REGIMM rt field (IR[20:16])
    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;

    // ALU operation codes (existing core encoding)
    localparam logic [4:0] ALU_ADDU  = 5'b00000;
    localparam logic [4:0] ALU_ADD   = 5'b00001;
    localparam logic [4:0] ALU_OR    = 5'b00010;
    localparam logic [4:0] ALU_SUBU  = 5'b00011;
    localparam logic [4:0] ALU_SUB   = 5'b00100;
    localparam logic [4:0] ALU_SLT   = 5'b00101;
    localparam logic [4:0] ALU_AND   = 5'b00110;
    localparam logic [4:0] ALU_NOR   = 5'b00111;
    localparam logic [4:0] ALU_XOR   = 5'b01001;
    localparam logic [4:0] ALU_SLL   = 5'b01010;
    localparam logic [4:0] ALU_SRL   = 5'b01011;
    localparam logic [4:0] ALU_SLTU  = 5'b01100;
    localparam logic [4:0] ALU_SLLV  = 5'b01111;
    localparam logic [4:0] ALU_SRA   = 5'b10000;
    localparam logic [4:0] ALU_SRAV  = 5'b10001;
    localparam logic [4:0] ALU_SRLV  = 5'b10010;
    localparam logic [4:0] ALU_LUI   = 5'b10011;
    localparam logic [4:0] ALU_SLTI  = 5'b10100;
    localparam logic [4:0] ALU_SLTIU = 5'b10101;

    // Datapath mux selects
    localparam logic [1:0] RD_RT    = 2'd0;
    localparam logic [1:0] RD_RD    = 2'd1;
    localparam logic [1:0] RD_RA    = 2'd2;
    localparam logic [1:0] M2R_ALU  = 2'd0;
    localparam logic [1:0] M2R_MEM  = 2'd1;
    localparam logic [1:0] M2R_PC4  = 2'd2;
    localparam logic [1:0] M2R_HILO = 2'd3;
    localparam logic [1:0] SRCB_RT  = 2'd0;
    localparam logic [1:0] SRCB_IMM = 2'd1;
    localparam logic [1:0] SRCB_4   = 2'd2;
    localparam logic [1:0] PC_SEQ   = 2'd0;
    localparam logic [1:0] PC_BR    = 2'd1;
    localparam logic [1:0] PC_JMP   = 2'd2;
    localparam logic [1:0] PC_RS    = 2'd3;
    localparam logic [1:0] BYTE_W   = 2'd0;
    localparam logic [1:0] BYTE_U   = 2'd2;
    localparam logic [1:0] BYTE_S   = 2'd3;
    localparam logic [1:0] MDU_MULT  = 2'd0;
    localparam logic [1:0] MDU_MULTU = 2'd1;
    localparam logic [1:0] MDU_DIV   = 2'd2;
    localparam logic [1:0] MDU_DIVU  = 2'd3;

    // Everything the FSM needs to know about the instruction in IR
    typedef struct packed {
        iclass_t    cls;
        logic [4:0] alu_ctr;
        logic       ext_op;
        logic [1:0] alu_src_b;
        logic [1:0] reg_dst;
        logic [1:0] byte_op;
        logic [1:0] mdu_op;
    } dec_t;

endpackage

// File: rtl/mc_instr_decode.sv
// Combinational instruction decoder: op/funct/rt to instruction class and
// per-instruction datapath fields.
module mc_instr_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic [4:0] rt_i,
    output dec_t       dec_o
);

    // Map the instruction fields to a class plus ALU/extend/memory/MDU fields
    always_comb begin
        dec_o           = '0;
        dec_o.cls       = C_ILLEGAL;
        dec_o.alu_src_b = SRCB_IMM;
        dec_o.reg_dst   = RD_RT;
        case (op_i)
            OP_RTYPE: begin
                dec_o.cls       = C_ALU_R;
                dec_o.alu_src_b = SRCB_RT;
                dec_o.reg_dst   = RD_RD;
                case (funct_i)
                    F_SLL:   dec_o.alu_ctr = ALU_SLL;
                    F_SRL:   dec_o.alu_ctr = ALU_SRL;
                    F_SRA:   dec_o.alu_ctr = ALU_SRA;
                    F_SLLV:  dec_o.alu_ctr = ALU_SLLV;
                    F_SRLV:  dec_o.alu_ctr = ALU_SRLV;
                    F_SRAV:  dec_o.alu_ctr = ALU_SRAV;
                    F_ADD:   dec_o.alu_ctr = ALU_ADD;
                    F_ADDU:  dec_o.alu_ctr = ALU_ADDU;
                    F_SUB:   dec_o.alu_ctr = ALU_SUB;
                    F_SUBU:  dec_o.alu_ctr = ALU_SUBU;
                    F_AND:   dec_o.alu_ctr = ALU_AND;
                    F_OR:    dec_o.alu_ctr = ALU_OR;
                    F_XOR:   dec_o.alu_ctr = ALU_XOR;
                    F_NOR:   dec_o.alu_ctr = ALU_NOR;
                    F_SLT:   dec_o.alu_ctr = ALU_SLT;
                    F_SLTU:  dec_o.alu_ctr = ALU_SLTU;
                    F_JR:    dec_o.cls = C_JR;
                    F_JALR:  dec_o.cls = C_JALR;
                    F_MFHI:  dec_o.cls = C_MFHI;
                    F_MFLO:  dec_o.cls = C_MFLO;
                    F_MTHI:  dec_o.cls = C_MTHI;
                    F_MTLO:  dec_o.cls = C_MTLO;
                    F_MULT:  begin dec_o.cls = C_MDU; dec_o.mdu_op = MDU_MULT;  end
                    F_MULTU: begin dec_o.cls = C_MDU; dec_o.mdu_op = MDU_MULTU; end
                    F_DIV:   begin dec_o.cls = C_MDU; dec_o.mdu_op = MDU_DIV;   end
                    F_DIVU:  begin dec_o.cls = C_MDU; dec_o.mdu_op = MDU_DIVU;  end
                    default: dec_o.cls = C_ILLEGAL;
                endcase
            end
            OP_REGIMM: begin
                if (rt_i == RT_BLTZ || rt_i == RT_BGEZ) begin
                    dec_o.cls     = C_BRANCH;
                    dec_o.alu_ctr = ALU_SUBU;
                    dec_o.ext_op  = 1'b1;
                end
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                dec_o.cls     = C_BRANCH;
                dec_o.alu_ctr = ALU_SUBU;
                dec_o.ext_op  = 1'b1;
            end
            OP_J:     dec_o.cls = C_J;
            OP_JAL:   dec_o.cls = C_JAL;
            OP_ADDI:  begin dec_o.cls = C_ALU_I; dec_o.alu_ctr = ALU_ADD;   dec_o.ext_op = 1'b1; end
            OP_ADDIU: begin dec_o.cls = C_ALU_I; dec_o.alu_ctr = ALU_ADDU;  dec_o.ext_op = 1'b1; end
            OP_SLTI:  begin dec_o.cls = C_ALU_I; dec_o.alu_ctr = ALU_SLTI;  dec_o.ext_op = 1'b1; end
            OP_SLTIU: begin dec_o.cls = C_ALU_I; dec_o.alu_ctr = ALU_SLTIU; dec_o.ext_op = 1'b1; end
            OP_ANDI:  begin dec_o.cls = C_ALU_I; dec_o.alu_ctr = ALU_AND;   end
            OP_ORI:   begin dec_o.cls = C_ALU_I; dec_o.alu_ctr = ALU_OR;    end
            OP_XORI:  begin dec_o.cls = C_ALU_I; dec_o.alu_ctr = ALU_XOR;   end
            OP_LUI:   begin dec_o.cls = C_ALU_I; dec_o.alu_ctr = ALU_LUI;   end
            OP_LW:    begin dec_o.cls = C_LOAD;  dec_o.alu_ctr = ALU_ADD; dec_o.ext_op = 1'b1; dec_o.byte_op = BYTE_W; end
            OP_LB:    begin dec_o.cls = C_LOAD;  dec_o.alu_ctr = ALU_ADD; dec_o.ext_op = 1'b1; dec_o.byte_op = BYTE_S; end
            OP_LBU:   begin dec_o.cls = C_LOAD;  dec_o.alu_ctr = ALU_ADD; dec_o.ext_op = 1'b1; dec_o.byte_op = BYTE_U; end
            OP_SW:    begin dec_o.cls = C_STORE; dec_o.alu_ctr = ALU_ADD; dec_o.ext_op = 1'b1; dec_o.byte_op = BYTE_W; end
            // a byte store carries no extension, so the unsigned code is used
            OP_SB:    begin dec_o.cls = C_STORE; dec_o.alu_ctr = ALU_ADD; dec_o.ext_op = 1'b1; dec_o.byte_op = BYTE_U; end
            default:  dec_o.cls = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory watchdog and retired-instruction
// counter. Optional macro ILLEGAL_TRAP_EN: unrecognised instructions halt
// the core and raise a sticky illegal flag instead of executing as a NOP.
//
// state  | meaning
// FETCH  | read instruction, load IR and PC+4 on mem_ready
// DECODE | latch decode class; jumps complete here
// EXEC   | ALU op, branch resolve, MDU start, HI/LO moves
// MEM    | load/store access held until mem_ready
// WB     | single-cycle register file write
// MDU    | wait for mult/div completion
// HALT   | watchdog or illegal trap; left only through rst
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTR_W    = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic [4:0]          rt,
    input  logic                mem_ready,
    input  logic                mdu_done,
    input  logic                branch_taken,
    output logic                pc_write,
    output logic                ir_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic [1:0]          reg_dst,
    output logic [1:0]          mem_to_reg,
    output logic [1:0]          alu_src_b,
    output logic [ALUCTR_W-1:0] alu_ctr,
    output logic                ext_op,
    output logic [1:0]          pc_src,
    output logic [1:0]          byte_op,
    output logic                mdu_start,
    output logic [1:0]          mdu_op,
    output logic                hi_we,
    output logic                lo_we,
    output logic                hilo_sel,
    output logic                retire,
    output logic [CNT_W-1:0]    retired_cnt,
    output logic                bus_err,
`ifdef ILLEGAL_TRAP_EN
    output logic                illegal,
`endif
    output logic [2:0]          state_o
);

    localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t            state_q, state_d;
    dec_t              dec_live, dec_q, dec;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              bus_err_q, bus_err_d;
`ifdef ILLEGAL_TRAP_EN
    logic              illegal_q, illegal_d;
`endif

    mc_instr_decode u_decode (
        .op_i    (op),
        .funct_i (funct),
        .rt_i    (rt),
        .dec_o   (dec_live)
    );

    // IR is only trusted in DECODE; later states use the latched copy
    assign dec = (state_q == S_DECODE) ? dec_live : dec_q;

    assign retired_cnt = cnt_q;
    assign bus_err     = bus_err_q;
    assign state_o     = state_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal     = illegal_q;
`endif

    // Next state, watchdog and all control outputs; everything is held at 0 during rst
    always_comb begin
        state_d    = state_q;
        wd_d       = '0;
        bus_err_d  = bus_err_q;
`ifdef ILLEGAL_TRAP_EN
        illegal_d  = illegal_q;
`endif
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = RD_RT;
        mem_to_reg = M2R_ALU;
        alu_src_b  = SRCB_RT;
        alu_ctr    = '0;
        ext_op     = 1'b0;
        pc_src     = PC_SEQ;
        byte_op    = BYTE_W;
        mdu_start  = 1'b0;
        mdu_op     = MDU_MULT;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        hilo_sel   = 1'b0;
        retire     = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_4;
                    alu_ctr   = ALUCTR_W'(ALU_ADDU);
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = PC_SEQ;
                        state_d  = S_DECODE;
                    end else if (MEM_TIMEOUT > 0) begin
                        if (int'(wd_q) == MEM_TIMEOUT - 1) begin
                            bus_err_d = 1'b1;
                            state_d   = S_HALT;
                        end else begin
                            wd_d = wd_q + WD_W'(1);
                        end
                    end
                end
                S_DECODE: begin
                    state_d = S_EXEC;
                    case (dec.cls)
                        C_J, C_JAL, C_JR, C_JALR: begin
                            pc_write = 1'b1;
                            pc_src   = (dec.cls == C_J || dec.cls == C_JAL) ? PC_JMP : PC_RS;
                            retire   = 1'b1;
                            state_d  = S_FETCH;
                            if (dec.cls == C_JAL || dec.cls == C_JALR) begin
                                reg_write  = 1'b1;
                                reg_dst    = (dec.cls == C_JAL) ? RD_RA : RD_RD;
                                mem_to_reg = M2R_PC4;
                            end
                        end
                        C_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
                            illegal_d = 1'b1;
                            state_d   = S_HALT;
`else
                            retire    = 1'b1;
                            state_d   = S_FETCH;
`endif
                        end
                        default: state_d = S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    alu_ctr   = ALUCTR_W'(dec.alu_ctr);
                    ext_op    = dec.ext_op;
                    alu_src_b = dec.alu_src_b;
                    state_d   = S_FETCH;
                    case (dec.cls)
                        C_ALU_R, C_ALU_I: state_d = S_WB;
                        C_LOAD, C_STORE:  state_d = S_MEM;
                        C_BRANCH: begin
                            pc_write = branch_taken;
                            pc_src   = PC_BR;
                            retire   = 1'b1;
                        end
                        C_MDU: begin
                            mdu_start = 1'b1;
                            mdu_op    = dec.mdu_op;
                            state_d   = S_MDU;
                        end
                        C_MTHI: begin hi_we = 1'b1; retire = 1'b1; end
                        C_MTLO: begin lo_we = 1'b1; retire = 1'b1; end
                        C_MFHI: begin hilo_sel = 1'b1; state_d = S_WB; end
                        C_MFLO: state_d = S_WB;
                        default: state_d = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    // keep the address path steady for the whole access
                    alu_ctr   = ALUCTR_W'(dec.alu_ctr);
                    ext_op    = dec.ext_op;
                    alu_src_b = dec.alu_src_b;
                    byte_op   = dec.byte_op;
                    mem_read  = (dec.cls == C_LOAD);
                    mem_write = (dec.cls == C_STORE);
                    if (mem_ready) begin
                        if (dec.cls == C_LOAD) begin
                            state_d = S_WB;
                        end else begin
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end
                    end else if (MEM_TIMEOUT > 0) begin
                        if (int'(wd_q) == MEM_TIMEOUT - 1) begin
                            bus_err_d = 1'b1;
                            state_d   = S_HALT;
                        end else begin
                            wd_d = wd_q + WD_W'(1);
                        end
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = dec.reg_dst;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                    if (dec.cls == C_LOAD) begin
                        mem_to_reg = M2R_MEM;
                        byte_op    = dec.byte_op;
                    end else if (dec.cls == C_MFHI || dec.cls == C_MFLO) begin
                        mem_to_reg = M2R_HILO;
                        hilo_sel   = (dec.cls == C_MFHI);
                    end
                end
                S_MDU: begin
                    mdu_op = dec.mdu_op;
                    if (mdu_done) begin
                        hi_we   = 1'b1;
                        lo_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_FETCH;
            endcase
        end
    end

    // State, latched decode, watchdog count, retire counter and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            dec_q     <= '0;
            wd_q      <= '0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            bus_err_q <= bus_err_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
            if (state_q == S_DECODE) dec_q <= dec_live;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control (MEM_TIMEOUT=4). Build with or
// without ILLEGAL_TRAP_EN.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op, funct;
    logic [4:0]  rt;
    logic        mem_ready, mdu_done, branch_taken;
    logic        pc_write, ir_write, mem_read, mem_write, reg_write;
    logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_src, byte_op, mdu_op;
    logic [4:0]  alu_ctr;
    logic        ext_op, mdu_start, hi_we, lo_we, hilo_sel, retire, bus_err;
    logic [31:0] retired_cnt;
    logic [2:0]  state_o;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int n_chk = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    multicycle_control #(.ALUCTR_W(5), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .rt(rt),
        .mem_ready(mem_ready), .mdu_done(mdu_done), .branch_taken(branch_taken),
        .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .alu_ctr(alu_ctr),
        .ext_op(ext_op), .pc_src(pc_src), .byte_op(byte_op),
        .mdu_start(mdu_start), .mdu_op(mdu_op), .hi_we(hi_we), .lo_we(lo_we),
        .hilo_sel(hilo_sel), .retire(retire), .retired_cnt(retired_cnt),
        .bus_err(bus_err),
`ifdef ILLEGAL_TRAP_EN
        .illegal(illegal),
`endif
        .state_o(state_o)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // one FETCH cycle with memory ready at once; op/funct belong to the fetched word
    task automatic do_fetch(input logic [5:0] o, input logic [5:0] f);
        op = o; funct = f; rt = 5'd0; mem_ready = 1'b1;
        #1;
        chk_eq("fetch_state", state_o, 3'd0);
        chk_eq("fetch_irw", ir_write, 1'b1);
        chk_eq("fetch_pcw", {pc_write, pc_src}, 3'b100);
        chk_eq("fetch_memwr", mem_write, 1'b0);
        chk_eq("fetch_cnt", retired_cnt, exp_cnt);
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; op = '0; funct = '0; rt = '0;
        mem_ready = 1'b1; mdu_done = 1'b0; branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk_eq("rst_state", state_o, 3'd0);
        chk_eq("rst_memrd", mem_read, 1'b0);
        chk_eq("rst_irw", ir_write, 1'b0);
        chk_eq("rst_cnt", retired_cnt, 32'd0);
        chk_eq("rst_buserr", bus_err, 1'b0);
        rst = 1'b0;

        // addu $3,$1,$2
        do_fetch(6'h00, 6'h21);
        #1 chk_eq("addu_dec", state_o, 3'd1); chk_eq("addu_dec_pcw", pc_write, 1'b0); cyc();
        #1 chk_eq("addu_exec", state_o, 3'd2); chk_eq("addu_alu", alu_ctr, 5'b00000);
        chk_eq("addu_srcb", alu_src_b, 2'd0); chk_eq("addu_exec_rw", reg_write, 1'b0); cyc();
        #1 chk_eq("addu_wb", state_o, 3'd4); chk_eq("addu_wb_rw", reg_write, 1'b1);
        chk_eq("addu_rdst", reg_dst, 2'd1); chk_eq("addu_m2r", mem_to_reg, 2'd0);
        chk_eq("addu_retire", retire, 1'b1); cyc(); exp_cnt++;
        #1 chk_eq("addu_back_rw", reg_write, 1'b0);

        // lw with mem_ready arriving on the 4th MEM cycle (watchdog boundary)
        do_fetch(6'h23, 6'h00);
        #1 chk_eq("lw_dec", state_o, 3'd1); cyc();
        #1 chk_eq("lw_exec", state_o, 3'd2); chk_eq("lw_alu", alu_ctr, 5'b00001);
        chk_eq("lw_ext", ext_op, 1'b1); chk_eq("lw_srcb", alu_src_b, 2'd1); cyc();
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b0;
            #1 chk_eq("lw_mem_wait", state_o, 3'd3); chk_eq("lw_memrd", mem_read, 1'b1);
            chk_eq("lw_byte", byte_op, 2'd0); cyc();
        end
        mem_ready = 1'b1;
        #1 chk_eq("lw_mem_last", state_o, 3'd3); chk_eq("lw_memrd_last", mem_read, 1'b1); cyc();
        #1 chk_eq("lw_wb", state_o, 3'd4); chk_eq("lw_m2r", mem_to_reg, 2'd1);
        chk_eq("lw_rdst", reg_dst, 2'd0); chk_eq("lw_rw", reg_write, 1'b1);
        chk_eq("lw_buserr", bus_err, 1'b0); cyc(); exp_cnt++;

        // beq taken, then bne not taken
        do_fetch(6'h04, 6'h00);
        branch_taken = 1'b1;
        #1 chk_eq("beq_dec", state_o, 3'd1); cyc();
        #1 chk_eq("beq_exec", state_o, 3'd2); chk_eq("beq_pc", {pc_write, pc_src}, 3'b101);
        chk_eq("beq_retire", retire, 1'b1); cyc(); exp_cnt++;
        do_fetch(6'h05, 6'h00);
        branch_taken = 1'b0;
        #1 chk_eq("bne_dec", state_o, 3'd1); cyc();
        #1 chk_eq("bne_exec", state_o, 3'd2); chk_eq("bne_pc", {pc_write, pc_src}, 3'b001);
        chk_eq("bne_retire", retire, 1'b1); cyc(); exp_cnt++;

        // sw completing immediately; next FETCH shows mem_write dropped
        do_fetch(6'h2B, 6'h00);
        #1 cyc();
        #1 chk_eq("sw_exec_alu", alu_ctr, 5'b00001); cyc();
        #1 chk_eq("sw_mem", state_o, 3'd3); chk_eq("sw_memwr", mem_write, 1'b1);
        chk_eq("sw_memrd", mem_read, 1'b0); chk_eq("sw_retire", retire, 1'b1); cyc(); exp_cnt++;

        // jal completes in DECODE
        do_fetch(6'h03, 6'h00);
        #1 chk_eq("jal_dec", state_o, 3'd1); chk_eq("jal_pc", {pc_write, pc_src}, 3'b110);
        chk_eq("jal_rw", {reg_write, reg_dst, mem_to_reg}, 5'b11010);
        chk_eq("jal_retire", retire, 1'b1); cyc(); exp_cnt++;

        // mfhi
        do_fetch(6'h00, 6'h10);
        #1 cyc();
        #1 chk_eq("mfhi_exec_sel", hilo_sel, 1'b1); cyc();
        #1 chk_eq("mfhi_wb", state_o, 3'd4); chk_eq("mfhi_m2r", mem_to_reg, 2'd3);
        chk_eq("mfhi_sel", hilo_sel, 1'b1); chk_eq("mfhi_rw", {reg_write, reg_dst}, 3'b101); cyc(); exp_cnt++;

        // mult with mdu_done on the 5th MDU cycle
        do_fetch(6'h00, 6'h18);
        #1 cyc();
        #1 chk_eq("mult_exec", state_o, 3'd2); chk_eq("mult_start", mdu_start, 1'b1);
        chk_eq("mult_op", mdu_op, 2'd0); cyc();
        for (int i = 0; i < 4; i++) begin
            mdu_done = 1'b0;
            #1 chk_eq("mult_wait", state_o, 3'd5); chk_eq("mult_start_drop", mdu_start, 1'b0);
            chk_eq("mult_we_wait", {hi_we, lo_we}, 2'b00); cyc();
        end
        mdu_done = 1'b1;
        #1 chk_eq("mult_done_we", {hi_we, lo_we}, 2'b11); chk_eq("mult_retire", retire, 1'b1); cyc();
        mdu_done = 1'b0; exp_cnt++;

        // watchdog: mem_ready held low in FETCH
        mem_ready = 1'b0;
        #1 chk_eq("wd_cnt", retired_cnt, exp_cnt);
        for (int i = 0; i < 4; i++) begin
            chk_eq("wd_wait_state", state_o, 3'd0);
            chk_eq("wd_wait_memrd", mem_read, 1'b1);
            chk_eq("wd_wait_buserr", bus_err, 1'b0);
            cyc(); #1;
        end
        chk_eq("wd_halt", state_o, 3'd6); chk_eq("wd_buserr", bus_err, 1'b1);
        chk_eq("wd_halt_memrd", mem_read, 1'b0);
        mem_ready = 1'b1;
        cyc(); #1;
        chk_eq("wd_halt_stay", state_o, 3'd6); chk_eq("halt_irw", ir_write, 1'b0);
        rst = 1'b1;
        #1 chk_eq("rst2_state", state_o, 3'd0); chk_eq("rst2_buserr", bus_err, 1'b0);
        chk_eq("rst2_cnt", retired_cnt, 32'd0); chk_eq("rst2_memrd", mem_read, 1'b0);
        cyc();
        rst = 1'b0; exp_cnt = 0;

        // unrecognised opcode
        do_fetch(6'h3F, 6'h00);
        #1 chk_eq("ill_dec", state_o, 3'd1);
        chk_eq("ill_we", {reg_write, pc_write, mem_write, hi_we, lo_we}, 5'b00000);
`ifdef ILLEGAL_TRAP_EN
        chk_eq("ill_retire", retire, 1'b0); cyc();
        #1 chk_eq("ill_halt", state_o, 3'd6); chk_eq("ill_flag", illegal, 1'b1);
        rst = 1'b1;
        #1 chk_eq("ill_rst_flag", illegal, 1'b0); chk_eq("ill_rst_state", state_o, 3'd0);
        cyc();
        rst = 1'b0;
`else
        chk_eq("ill_retire", retire, 1'b1); cyc(); exp_cnt++;
        do_fetch(6'h00, 6'h21);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle control decoder of the MIPS core.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Waits on a variable-latency memory (mem_ready) and a multi-cycle mult/div unit (mdu_done).
- Adds a memory watchdog and a retired-instruction counter.
- Sits between the IR/PC datapath and the ALU, register file, memory and HI/LO unit.

Parameters:
- ALUCTR_W, 5: width of alu_ctr; codes match the existing core ALU encoding.
- MEM_TIMEOUT, 16: maximum wait cycles for mem_ready in FETCH or MEM; 0 disables the watchdog.
- CNT_W, 32: width of retired_cnt.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- rt  in  5  IR[20:16]; selects bgez/bltz.
- mem_ready  in  1  memory access completes this cycle.
- mdu_done  in  1  mult/div result valid this cycle.
- branch_taken  in  1  branch condition from the compare unit.
- pc_write  out  1  PC load enable.
- ir_write  out  1  IR load enable.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write enable.
- reg_dst  out  2  0=rt, 1=rd, 2=$31.
- mem_to_reg  out  2  0=ALU, 1=memory, 2=PC+4, 3=HI/LO.
- alu_src_b  out  2  0=rt, 1=extended immediate, 2=constant 4.
- alu_ctr  out  ALUCTR_W  ALU operation.
- ext_op  out  1  1=sign-extend, 0=zero-extend.
- pc_src  out  2  0=PC+4, 1=branch target, 2=jump target, 3=rs.
- byte_op  out  2  0=word, 2=byte unsigned, 3=byte signed.
- mdu_start  out  1  one-cycle pulse that starts the MDU.
- mdu_op  out  2  0=mult, 1=multu, 2=div, 3=divu.
- hi_we, lo_we  out  1 each  HI/LO write enables.
- hilo_sel  out  1  0=LO, 1=HI; read select for mfhi/mflo.
- retire  out  1  one-cycle pulse on instruction completion.
- retired_cnt  out  CNT_W  count of retired instructions; wraps.
- bus_err  out  1  sticky watchdog flag.
- state_o  out  3  current state.

Behaviour:
- Reset:
  - While rst is high, state=FETCH, all control outputs are 0, retired_cnt=0 and bus_err=0.
  - The first cycle after release presents FETCH outputs.
  - Reset asserted mid-instruction aborts it with no write enable asserted.
- Control outputs are combinational from state, the latched decode class and the qualifiers (mem_ready, mdu_done, branch_taken).
- State and counters are registered.
- op, funct and rt are latched only in DECODE.
- FETCH (0):
  - mem_read=1 throughout.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, next state DECODE.
  - Otherwise remain in FETCH.
- DECODE (1):
  - j: pc_write=1, pc_src=2.
  - jal: additionally reg_write=1, reg_dst=2, mem_to_reg=2.
  - jr: pc_src=3.
  - jalr: pc_src=3, reg_dst=1, reg_write=1, mem_to_reg=2.
  - All jumps retire and go to FETCH in one cycle.
  - Every other instruction goes to EXEC.
- EXEC (2):
  - ALU R/I-type: drive alu_ctr/ext_op/alu_src_b, then go to WB.
  - Loads and stores: alu_ctr=add, ext_op=1, then go to MEM.
  - Branches (beq/bne/bgez/bltz/bgtz/blez): pc_write=branch_taken, pc_src=1, retire, go to FETCH.
  - mult/multu/div/divu: mdu_start=1 for this cycle only, then go to MDU.
  - mthi/mtlo: hi_we or lo_we=1, retire, go to FETCH.
  - mfhi/mflo: go to WB with mem_to_reg=3 and hilo_sel set.
- MEM (3):
  - Hold mem_read (load) or mem_write (store) plus byte_op until mem_ready.
  - Load then goes to WB; store retires and goes to FETCH.
  - A write is never repeated: mem_write drops the cycle after mem_ready.
- WB (4): reg_write=1 for exactly one cycle, retire, go to FETCH.
- MDU (5): wait for mdu_done; on that cycle hi_we=lo_we=1, retire, go to FETCH.
- HALT (6):
  - All enables are 0. Exit only via rst.
- Watchdog:
  - Counts cycles spent waiting in FETCH or MEM; clears on mem_ready or on a state change.
  - When MEM_TIMEOUT>0 and the count reaches MEM_TIMEOUT, set bus_err and go to HALT.
  - If mem_ready arrives on the same cycle the count reaches MEM_TIMEOUT, mem_ready wins.
- Writes to register 0 are not suppressed here; the register file ignores them.
- retired_cnt increments on every retire pulse; it wraps from 2^CNT_W-1 to 0.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an unrecognised op or R-type funct in DECODE goes to HALT and sets a sticky illegal output (1 bit, reset 0).
- Undefined: unrecognised instructions execute as a NOP: DECODE goes directly to FETCH with retire=1 and no write enable asserted. The illegal port is absent.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state encoding;
  - opcode, funct and rt constants;
  - the ALUCtr codes: addu 00000, add 00001, or 00010, subu 00011, sub 00100, slt 00101, and 00110, nor 00111, xor 01001, sll 01010, srl 01011, sltu 01100, sllv 01111, sra 10000, srav 10001, srlv 10010, lui 10011, slti 10100, sltiu 10101;
  - the reg_dst, mem_to_reg, pc_src and byte_op encodings.
- Sub-module mc_instr_decode is purely combinational. It maps op/funct/rt to the instruction class, alu_ctr, ext_op, byte_op and mdu_op. The FSM registers its class output in DECODE.

Test Plan:
- addu $3,$1,$2 with mem_ready=1 immediately → states 0,1,2,4,0; reg_write high one cycle with reg_dst=1, alu_ctr=00000; retired_cnt 0→1.
- lw with mem_ready delayed 3 cycles in MEM → mem_read held 4 cycles; WB mem_to_reg=1; total 8 cycles.
- beq with branch_taken=1, then bne with branch_taken=0 → pc_write=1, pc_src=1 in the first EXEC; pc_write=0 in the second; each takes 3 cycles.
- mult with mdu_done after 5 cycles → mdu_start exactly 1 cycle; hi_we=lo_we=1 on the done cycle; next state FETCH.
- mem_ready held low with MEM_TIMEOUT=4 → bus_err=1 and state 6 after 4 wait cycles; rst clears both.
- op=6'b111111 → with ILLEGAL_TRAP_EN: illegal=1, HALT; without: retire=1 with no write enable asserted, then FETCH.
